// File: rtl/prog_pulser.sv
// prog_pulser: run-time programmable pulse and tick generator.
//
// Drives a PWM-style pulse `p` and a one-cycle `tick` strobe at the end of
// each period. It runs free (mode=0) or as a single triggered shot (mode=1).
// Period and high-width can be reloaded while running without glitching the
// current period.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   en         run enable; low forces IDLE
//   mode       0 = free-run, 1 = one-shot (sampled only in IDLE)
//   trig       one-shot start; phase resync in free-run
//   load       one-cycle request to load period_in/width_in
//   period_in  requested period in cycles (>= 1)
//   width_in   requested high-width in cycles (<= period_in)
//   p          registered pulse output
//   tick       registered one-cycle strobe at the end of each period
//   busy       high while running or in a shot
//   cfg_err    one-cycle strobe when a load is rejected
module prog_pulser #(
    parameter int unsigned      CNT_W      = 33,
    parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(6250000),
    parameter logic [CNT_W-1:0] DEF_WIDTH  = CNT_W'(2500000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             trig,
    input  logic             load,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] width_in,
    output logic             p,
    output logic             tick,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StShot
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] pend_period_q, pend_period_d;
    logic [CNT_W-1:0] pend_width_q, pend_width_d;
    logic             pend_valid_q, pend_valid_d;
    logic             p_q, p_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             cfg_err_q, cfg_err_d;

    logic active;
    logic at_end;
    logic cfg_ok;
    logic load_ok;
    logic apply_evt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            count_q       <= '0;
            period_q      <= DEF_PERIOD;
            width_q       <= DEF_WIDTH;
            pend_period_q <= '0;
            pend_width_q  <= '0;
            pend_valid_q  <= 1'b0;
            p_q           <= 1'b0;
            tick_q        <= 1'b0;
            busy_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            period_q      <= period_d;
            width_q       <= width_d;
            pend_period_q <= pend_period_d;
            pend_width_q  <= pend_width_d;
            pend_valid_q  <= pend_valid_d;
            p_q           <= p_d;
            tick_q        <= tick_d;
            busy_q        <= busy_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        period_d      = period_q;
        width_d       = width_q;
        pend_period_d = pend_period_q;
        pend_width_d  = pend_width_q;
        pend_valid_d  = pend_valid_q;
        apply_evt     = 1'b0;

        active  = (state_q != StIdle);
        // count never exceeds period_q-1, so this is the last cycle of a period
        at_end  = (count_q == period_q - CNT_W'(1));
        cfg_ok  = (period_in != '0) && (width_in <= period_in);
        load_ok = load && cfg_ok;

        case (state_q)
            StIdle: begin
                count_d = '0;
                if (en) begin
                    if (!mode) begin
                        state_d = StRun;
                    end else if (trig) begin
                        state_d = StShot;
                    end
                end
            end
            StRun: begin
                if (!en) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (trig || at_end) begin
                    // Wrap or phase resync: both are safe points to swap config
                    count_d   = '0;
                    apply_evt = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            StShot: begin
                if (!en) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (at_end) begin
                    state_d   = StIdle;
                    count_d   = '0;
                    apply_evt = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase

        // Config update: direct in IDLE, at a period boundary when running,
        // otherwise parked in the shadow until the next boundary.
        if (!active) begin
            if (load_ok) begin
                period_d     = period_in;
                width_d      = width_in;
                pend_valid_d = 1'b0;
            end
        end else if (apply_evt) begin
            if (load_ok) begin
                // Same-cycle load beats any older shadow contents
                period_d     = period_in;
                width_d      = width_in;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                period_d     = pend_period_q;
                width_d      = pend_width_q;
                pend_valid_d = 1'b0;
            end
        end else if (load_ok) begin
            pend_period_d = period_in;
            pend_width_d  = width_in;
            pend_valid_d  = 1'b1;
        end

        p_d       = active && (count_q < width_q);
        tick_d    = active && at_end;
        busy_d    = (state_d != StIdle);
        cfg_err_d = load && !cfg_ok;
    end

    assign p       = p_q;
    assign tick    = tick_q;
    assign busy    = busy_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_prog_pulser.sv
module tb_prog_pulser;

    localparam int unsigned CNT_W = 33;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             mode;
    logic             trig;
    logic             load;
    logic [CNT_W-1:0] period_in;
    logic [CNT_W-1:0] width_in;
    logic             p;
    logic             tick;
    logic             busy;
    logic             cfg_err;

    int n_cmp;
    int n_fail;

    prog_pulser #(
        .CNT_W     (CNT_W),
        .DEF_PERIOD(33'd5),
        .DEF_WIDTH (33'd2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .trig     (trig),
        .load     (load),
        .period_in(period_in),
        .width_in (width_in),
        .p        (p),
        .tick     (tick),
        .busy     (busy),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and compare {p, tick, busy, cfg_err} 1 ns after the edge.
    task automatic step(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        @(posedge clk);
        #1;
        obs = {p, tick, busy, cfg_err};
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: {p,tick,busy,cfg_err} got %b want %b", tag, obs, exp);
        end
    endtask

    // Expect cnt running cycles starting at count `first` for period n, width w.
    task automatic check_run(input string tag, input int w, input int n, input int first,
                             input int cnt);
        int i;
        for (int k = 0; k < cnt; k++) begin
            i = (first + k) % n;
            step($sformatf("%s[%0d]", tag, k), {(i < w), (i == n - 1), 1'b1, 1'b0});
        end
    endtask

    task automatic do_load(input int per, input int wid);
        load      = 1'b1;
        period_in = CNT_W'(per);
        width_in  = CNT_W'(wid);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        mode      = 1'b0;
        trig      = 1'b0;
        load      = 1'b0;
        period_in = '0;
        width_in  = '0;

        // Reset
        step("rst0", 4'b0000);
        step("rst1", 4'b0000);
        step("rst2", 4'b0000);

        // Free-run with defaults 5/2
        rst_n = 1'b1;
        en    = 1'b1;
        step("run_start", 4'b0010);
        check_run("run_def", 2, 5, 0, 10);

        // Load 8/6 mid-period: deferred to the wrap
        step("ld_c0", 4'b1010);
        do_load(8, 6);
        step("ld_c1", 4'b1010);
        load = 1'b0;
        check_run("ld_rest", 2, 5, 2, 3);
        check_run("ld_8_6", 6, 8, 0, 16);

        // Load 5/3 in the wrap cycle: applied immediately
        check_run("pre_wrap", 6, 8, 0, 7);
        do_load(5, 3);
        step("ld_wrap", 4'b0110);
        load = 1'b0;
        check_run("after_wrap", 3, 5, 0, 5);

        // Invalid loads
        do_load(4, 5);
        step("bad_w", 4'b1011);
        load = 1'b0;
        check_run("bad_w_run", 3, 5, 1, 4);
        do_load(0, 0);
        step("bad_p0", 4'b1011);
        load = 1'b0;
        check_run("bad_p0_run", 3, 5, 1, 4);
        check_run("bad_keep", 3, 5, 0, 5);

        // width = 0
        do_load(5, 0);
        step("w0_ld", 4'b1010);
        load = 1'b0;
        check_run("w0_pre", 3, 5, 1, 4);
        check_run("w0", 0, 5, 0, 5);

        // width = period = 3
        do_load(3, 3);
        step("full_ld", 4'b0010);
        load = 1'b0;
        check_run("full_pre", 0, 5, 1, 4);
        check_run("full", 3, 3, 0, 6);

        // period = 1
        do_load(1, 1);
        step("p1_ld", 4'b1010);
        load = 1'b0;
        check_run("p1_pre", 3, 3, 1, 2);
        check_run("p1", 1, 1, 0, 4);

        // Back to 5/2 (bypass at a period-1 wrap), then trig at count 3
        do_load(5, 2);
        step("back_ld", 4'b1110);
        load = 1'b0;
        check_run("trig_pre", 2, 5, 0, 3);
        trig = 1'b1;
        step("trig_c3", 4'b0010);
        trig = 1'b0;
        check_run("trig_post", 2, 5, 0, 5);

        // Leave RUN via en=0
        check_run("stop_pre", 2, 5, 0, 3);
        en = 1'b0;
        step("stop", 4'b0000);
        step("idle", 4'b0000);

        // One-shot, with an ignored retrigger
        en   = 1'b1;
        mode = 1'b1;
        step("shot_wait", 4'b0000);
        trig = 1'b1;
        step("shot_go", 4'b0010);
        trig = 1'b0;
        step("shot_c0", 4'b1010);
        step("shot_c1", 4'b1010);
        trig = 1'b1;
        step("shot_c2", 4'b0010);
        trig = 1'b0;
        step("shot_c3", 4'b0010);
        step("shot_c4", 4'b0100);
        step("shot_done", 4'b0000);
        step("shot_idle", 4'b0000);

        // Abort a shot
        trig = 1'b1;
        step("ab_go", 4'b0010);
        trig = 1'b0;
        step("ab_c0", 4'b1010);
        step("ab_c1", 4'b1010);
        step("ab_c2", 4'b0010);
        en = 1'b0;
        step("ab_stop", 4'b0000);
        step("ab_idle", 4'b0000);

        // Reset with a pending load: defaults must come back, shadow dropped
        en   = 1'b1;
        mode = 1'b0;
        step("rp_start", 4'b0010);
        do_load(8, 1);
        step("rp_c0", 4'b1010);
        load = 1'b0;
        step("rp_c1", 4'b1010);
        rst_n = 1'b0;
        step("rp_rst", 4'b0000);
        rst_n = 1'b1;
        step("rp_restart", 4'b0010);
        check_run("rp_def", 2, 5, 0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_pulser.md
Name: prog_pulser

Overview:
Run-time programmable successor to the fixed-period game-timing pulser. It generates a PWM-style pulse `p` and a one-cycle `tick` strobe from a single clock, in free-run or one-shot mode. Period and high-width are loadable while running, so game logic can change ball/paddle speed without glitches. It sits between the system clock and the Pong motion/CPU-paddle logic.

Parameters:
CNT_W, 33, width of counter, period and width registers.
DEF_PERIOD, 6250000, period (cycles) loaded at reset; must be >= 1.
DEF_WIDTH, 2500000, high-width (cycles) loaded at reset; must be <= DEF_PERIOD.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  synchronous active-low reset.
en  in  1  run enable; low forces IDLE.
mode  in  1  0 = free-run, 1 = one-shot; sampled only in IDLE.
trig  in  1  one-shot start; in free-run, resynchronises phase.
load  in  1  one-cycle request to load period_in/width_in.
period_in  in  CNT_W  requested period in cycles.
width_in  in  CNT_W  requested high-width in cycles.
p  out  1  registered pulse output.
tick  out  1  registered one-cycle strobe at end of each period.
busy  out  1  high while in RUN or SHOT.
cfg_err  out  1  one-cycle strobe when a load is rejected.

Behaviour:
- Reset is synchronous: on a posedge clk with rst_n=0, the block sets:
  - state=IDLE, count=0, period_r=DEF_PERIOD, width_r=DEF_WIDTH.
  - pend_valid=0, p=0, tick=0, busy=0, cfg_err=0.
  - A reset mid-operation discards any pending load.
- States and transitions:
  - IDLE: count held at 0. If en=1 and mode=0, go to RUN. If en=1, mode=1 and trig=1, go to SHOT.
  - RUN: count increments each cycle and wraps to 0 after period_r-1.
  - SHOT: same counting as RUN. At count==period_r-1, go to IDLE instead of wrapping.
  - From RUN or SHOT, en=0 returns to IDLE on the next edge with count<=0. This aborts a one-shot.
- Output timing:
  - p <= active & (count < width_r), registered, so p lags count by one cycle.
  - tick <= active & (count == period_r-1), with the same one-cycle lag.
  - busy <= (next state != IDLE).
  - active means state is RUN or SHOT.
- Boundary values:
  - width_r=0: p stays 0.
  - width_r=period_r: p stays 1 while active.
  - period_r=1: count stays 0 and tick=1 every active cycle.
- Trigger rules:
  - trig in RUN: count<=0 on the next edge (phase resync). No tick is emitted for the truncated period.
  - trig in SHOT: ignored; the one-shot is not retriggerable.
  - mode changes outside IDLE are ignored until the block returns to IDLE.
- Load validation: a load is valid iff period_in >= 1 and width_in <= period_in.
  - An invalid load raises cfg_err for 1 cycle; registers and pending state are unchanged.
- Applying a valid load:
  - In IDLE: period_r and width_r update on the next edge.
  - In RUN or SHOT: values go to a pending shadow (pend_valid=1) and are applied at the next edge where count==period_r-1 (wrap or shot end). The transfer clears pend_valid.
  - A new load while pend_valid=1 overwrites the shadow.
  - A load in the same cycle as a wrap is applied at that wrap (bypass), not deferred.
- trig resync with pend_valid=1 also applies the pending values.
- Counter arithmetic is unsigned CNT_W-bit. count never reaches period_r, so there is no overflow.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then en=1, mode=0, DEF_PERIOD=5, DEF_WIDTH=2 -> busy=1; p pattern 1,1,0,0,0 repeating with period 5; tick high once every 5 cycles, coinciding with the last p=0.
- One-shot: DEF 5/2, mode=1, en=1, one-cycle trig -> exactly one 2-high/3-low window and one tick, busy=0 after; a trig during SHOT is ignored and produces no extension.
- Load in RUN: running 5/2, load period_in=8, width_in=6 mid-period -> current period finishes at 5; next periods show 6 high, 2 low; load coinciding with the wrap cycle takes effect immediately.
- Invalid load: period_in=4, width_in=5, and separately period_in=0 -> cfg_err 1-cycle pulse each time; p/tick pattern unchanged.
- Corners: width=0 -> p=0 constantly; width=period=3 -> p=1 constantly; period=1 -> tick every cycle; trig in RUN at count=3 of 5 -> count restarts at 0, no tick for that period.
- Abort and reset: en=0 mid-SHOT -> IDLE next edge, then p=0, tick=0, busy=0; rst_n=0 with a pending load -> defaults restored and the pending load is never applied.
